mult_hazard_ctrl: RTL and testbench
===================================

// Module: mult_hazard_ctrl
// PURPOSE
//  Sequencer and hazard controller for the iterative HI/LO multiplier in the execute stage.
//  - Accepts StartMultE/MultSignE/OutSelectE as registered into E by the decode/execute pipeline register.
//  - Runs a multi-cycle shift-add multiply into HI/LO.
//  - Stalls F, D and the D/E register and bubbles E->M while an E-stage instruction conflicts with a busy multiply.
// PARAMETERS
//  BITS_PER_CYCLE  1   multiplier bits retired per RUN cycle; legal 1,2,4; N = 32/BITS_PER_CYCLE
// PORTS
//  Clk         in   1   clock, rising edge
//  Rst_n       in   1   asynchronous reset, active low
//  StartMultE  in   1   E-stage instruction is MULT/MULTU
//  MultSignE   in   1   1 = signed (MULT), 0 = unsigned (MULTU)
//  OutSelectE  in   2   00 ALU, 01 read HI (MFHI), 10 read LO (MFLO), 11 = ALU
//  SrcAE       in   32  multiplicand (forwarded E operand A)
//  SrcBE       in   32  multiplier (forwarded E operand B)
//  StallFD     out  1   1 = hold PC, F/D and D/E registers (drives D/E En)
//  FlushM      out  1   1 = load bubble into E/M register this cycle
//  MultBusy    out  1   state != IDLE
//  HiLoOutE    out  32  HI if OutSelectE==01, LO if 10, else 0
//  HiOut       out  32  architectural HI
//  LoOut       out  32  architectural LO
// BEHAVIOUR
//  - Reset: Rst_n low clears state to IDLE, counter, HI, LO, all internal regs.
//    Outputs then: StallFD=0, FlushM=0, MultBusy=0, HiOut=LoOut=0, HiLoOutE=0.
//    Reset mid-RUN abandons the operation; HI/LO = 0.
//  - States: IDLE, RUN.
//  - IDLE->RUN at edge when StartMultE=1 in IDLE:
//    - latch |SrcAE|, |SrcBE| (magnitude only if MultSignE, else raw);
//    - latch negate flag = MultSignE & (SrcAE[31]^SrcBE[31]);
//    - clear 64-bit accumulator; counter = 0.
//  - RUN: each cycle add (multiplicand << shift) * next BITS_PER_CYCLE multiplier bits into accumulator; counter++.
//  - RUN->IDLE at edge ending the N-th RUN cycle. Same edge: {HI,LO} = negate ? -acc : acc (64-bit two's complement).
//  - Latency: start accepted cycle c0, RUN c1..cN, new HI/LO visible in cN+1.
//  - Arithmetic: magnitudes are 32-bit unsigned; |0x80000000| = 0x80000000.
//    Accumulator is 64 bit, no overflow possible.
//  - Hazard: StallFD = FlushM = MultBusy & (StartMultE | OutSelectE==01 | OutSelectE==10). Combinational.
//  - Stalled instruction stays in E. Next-start or HI/LO read proceeds in cN+1; a stalled MULT starts in cN+1 with no gap.
//  - StartMultE in IDLE never stalls; the start cycle itself is stall-free.
//  - ALU-only instructions (OutSelectE 00/11) never stall while busy.
//  - HiLoOutE reads current HI/LO, combinational, no forwarding of in-flight result (stall guarantees correctness).
//  - Simultaneous: StartMultE with OutSelectE!=00 is illegal encoding; treat as start.
//  - StartMultE deasserted by a D/E clear during RUN has no effect on the running op.
// CONFIGURATION
//  MULT_EARLY_TERM_EN defined:
//    - RUN also exits at the edge where remaining unshifted multiplier bits are all zero (after >=1 RUN cycle);
//    - result as above; latency 1..N cycles.
//  MULT_EARLY_TERM_EN undefined: fixed N RUN cycles regardless of operands.
// TESTING
//  - Reset: Rst_n=0 mid-RUN -> MultBusy=0, StallFD=0, HiOut=LoOut=0 immediately; no later writeback.
//  - MULTU 7*6, BITS_PER_CYCLE=1, no EN -> MultBusy for 32 cycles; cycle 33 Hi=0, Lo=0x0000002A.
//  - MULT -3*5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
//    MULT 0x80000000*0xFFFFFFFF -> Hi=0, Lo=0x80000000.
//  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
//  - MFLO in E at c1 -> StallFD=FlushM=1 c1..c32, 0 in c33, HiLoOutE=new Lo in c33.
//    ADD in E while busy -> StallFD=0.
//  - Back-to-back MULT: second MULT in E at c1 stalls c1..cN, starts in cN+1; first result visible in cN+1.
//    Second result in c2N+2.
//  - MULT_EARLY_TERM_EN: MULTU 5*3, BITS_PER_CYCLE=1 -> RUN 2 cycles, Lo=0x0F.
//    Without macro same op takes 32 cycles.

Source files
------------

// File: rtl/mult_hazard_ctrl.sv
// mult_hazard_ctrl: iterative HI/LO shift-add multiplier sequencer with E-stage hazard stall/flush.
// Optional MULT_EARLY_TERM_EN ends RUN once the remaining multiplier bits are all zero.
module mult_hazard_ctrl #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        StartMultE,
  input  logic        MultSignE,
  input  logic [1:0]  OutSelectE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        StallFD,
  output logic        FlushM,
  output logic        MultBusy,
  output logic [31:0] HiLoOutE,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut
);
  localparam int N = 32 / BITS_PER_CYCLE;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [63:0] mcand, acc, pp, acc_nx, res;
  logic [31:0] mplier, mplier_nx, mag_a, mag_b, hi, lo;
  logic [5:0]  cnt;
  logic        neg, last, done, hilo_rd;

  assign mag_a = (MultSignE && SrcAE[31]) ? -SrcAE : SrcAE;
  assign mag_b = (MultSignE && SrcBE[31]) ? -SrcBE : SrcBE;

  // Partial product for the next BITS_PER_CYCLE multiplier bits; mcand is pre-shifted.
  always_comb begin
    pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++)
      pp = pp + (mplier[i] ? (mcand << i) : 64'd0);
  end

  assign acc_nx    = acc + pp;
  assign mplier_nx = mplier >> BITS_PER_CYCLE;
  assign last      = cnt == 6'(N - 1);
  assign res       = neg ? -acc_nx : acc_nx;

`ifdef MULT_EARLY_TERM_EN
  assign done = last || (mplier_nx == '0);
`else
  assign done = last;
`endif

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (StartMultE ? RUN : IDLE) : (done ? IDLE : RUN);
  end

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == IDLE && StartMultE) begin
      mcand  <= {32'd0, mag_a};
      mplier <= mag_b;
      neg    <= MultSignE && (SrcAE[31] ^ SrcBE[31]);
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_nx;
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier_nx;
      cnt    <= cnt + 6'd1;
      if (done) {hi, lo} <= res;
    end

  // The stall holds HI/LO readers in E until the writeback, so no forwarding is needed.
  assign hilo_rd  = (OutSelectE == 2'b01) || (OutSelectE == 2'b10);
  assign MultBusy = state == RUN;
  assign StallFD  = MultBusy && (StartMultE || hilo_rd);
  assign FlushM   = StallFD;
  assign HiLoOutE = (OutSelectE == 2'b01) ? hi : (OutSelectE == 2'b10) ? lo : 32'd0;
  assign HiOut    = hi;
  assign LoOut    = lo;
endmodule

// File: tb/tb_mult_hazard_ctrl.sv
// tb_mult_hazard_ctrl: scoreboard bench for mult_hazard_ctrl (default or MULT_EARLY_TERM_EN build).
module tb_mult_hazard_ctrl;
  localparam int BPC = 1;
  localparam int N = 32 / BPC;
`ifdef MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        Clk = 1'b0, Rst_n = 1'b0, StartMultE = 1'b0, MultSignE = 1'b0;
  logic [1:0]  OutSelectE = 2'b00;
  logic [31:0] SrcAE = '0, SrcBE = '0;
  logic        StallFD, FlushM, MultBusy;
  logic [31:0] HiLoOutE, HiOut, LoOut;

  int n_tests = 0, n_fail = 0;
  logic [63:0] sbq[$];
  logic [31:0] cur_hi = '0, cur_lo = '0;

  mult_hazard_ctrl #(.BITS_PER_CYCLE(BPC)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .StartMultE(StartMultE), .MultSignE(MultSignE),
    .OutSelectE(OutSelectE), .SrcAE(SrcAE), .SrcBE(SrcBE), .StallFD(StallFD),
    .FlushM(FlushM), .MultBusy(MultBusy), .HiLoOutE(HiLoOutE), .HiOut(HiOut), .LoOut(LoOut)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = s ? 64'(sa * sb) : ({32'd0, a} * {32'd0, b});
    return p;
  endfunction

  function automatic int exp_lat(input logic [31:0] b, input logic s);
    logic [31:0] m;
    int h;
    m = (s && b[31]) ? -b : b;
    h = 0;
    for (int i = 0; i < 32; i++) if (m[i]) h = i;
    return ET ? h / BPC + 1 : N;
  endfunction

  function automatic logic [31:0] sel_val(input logic [1:0] sel, input logic [31:0] h, input logic [31:0] l);
    return (sel == 2'b01) ? h : (sel == 2'b10) ? l : 32'd0;
  endfunction

  task automatic test_reset();
    #3;
    n_tests++;
    if ({StallFD, FlushM, MultBusy} !== 3'b000 || HiOut !== 0 || LoOut !== 0 || HiLoOutE !== 0) begin
      n_fail++;
      $display("FAIL reset: stall=%b flush=%b busy=%b hi=%h lo=%h hilo=%h, want all 0",
               StallFD, FlushM, MultBusy, HiOut, LoOut, HiLoOutE);
    end
    tick();
    Rst_n = 1'b1;
    tick();
  endtask

  // One multiply with OutSelectE=sel held in E while it runs.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [1:0] sel);
    int k;
    logic [63:0] exp;
    logic stall_exp;
    StartMultE = 1'b1; MultSignE = s; SrcAE = a; SrcBE = b; OutSelectE = 2'b00;
    #1;
    n_tests++;
    if (StallFD !== 1'b0 || MultBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_cycle: stall=%b busy=%b, want 0 0", StallFD, MultBusy);
    end
    sbq.push_back(ref_prod(a, b, s));
    tick();
    StartMultE = 1'b0; OutSelectE = sel; SrcAE = $urandom; SrcBE = $urandom;
    stall_exp = (sel == 2'b01) || (sel == 2'b10);
    #1;
    k = 0;
    while (MultBusy === 1'b1 && k < 200) begin
      k++;
      n_tests++;
      if (StallFD !== stall_exp || FlushM !== stall_exp || HiLoOutE !== sel_val(sel, cur_hi, cur_lo)) begin
        n_fail++;
        $display("FAIL run_c%0d sel=%b: stall=%b flush=%b hilo=%h, want %b %b %h", k, sel,
                 StallFD, FlushM, HiLoOutE, stall_exp, stall_exp, sel_val(sel, cur_hi, cur_lo));
      end
      tick();
      #1;
    end
    exp = sbq.size() > 0 ? sbq.pop_front() : 64'hx;
    n_tests++;
    if (k !== exp_lat(b, s)) begin
      n_fail++;
      $display("FAIL latency %h*%h: got %0d run cycles, want %0d", a, b, k, exp_lat(b, s));
    end
    n_tests++;
    if (HiOut !== exp[63:32] || LoOut !== exp[31:0]) begin
      n_fail++;
      $display("FAIL result %h*%h s=%b: hi=%h lo=%h, want %h %h", a, b, s, HiOut, LoOut, exp[63:32], exp[31:0]);
    end
    cur_hi = exp[63:32];
    cur_lo = exp[31:0];
    n_tests++;
    if (StallFD !== 1'b0 || FlushM !== 1'b0 || HiLoOutE !== sel_val(sel, cur_hi, cur_lo)) begin
      n_fail++;
      $display("FAIL release sel=%b: stall=%b flush=%b hilo=%h, want 0 0 %h", sel,
               StallFD, FlushM, HiLoOutE, sel_val(sel, cur_hi, cur_lo));
    end
    OutSelectE = 2'b00;
    tick();
  endtask

  task automatic test_mult();
    do_mult(32'd7, 32'd6, 1'b0, 2'b00);
    do_mult(-32'sd3, 32'd5, 1'b1, 2'b01);
    do_mult(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2'b10);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b11);
    do_mult(32'd5, 32'd3, 1'b0, 2'b10);
    do_mult(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 2'b01);
    do_mult(32'hDEAD_BEEF, 32'd0, 1'b1, 2'b00);
    for (int j = 0; j < 4; j++)
      do_mult($urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
  endtask

  // Second MULT sits stalled in E and starts the cycle the first one writes back.
  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] exp;
    int k;
    a1 = 32'hFFFF_FFF9; b1 = 32'h0000_0123; a2 = 32'h0001_0001; b2 = 32'h8000_0001;
    StartMultE = 1'b1; MultSignE = 1'b1; SrcAE = a1; SrcBE = b1; OutSelectE = 2'b00;
    sbq.push_back(ref_prod(a1, b1, 1'b1));
    tick();
    MultSignE = 1'b0; SrcAE = a2; SrcBE = b2;
    #1;
    k = 0;
    while (MultBusy === 1'b1 && k < 200) begin
      k++;
      n_tests++;
      if (StallFD !== 1'b1 || FlushM !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_stall_c%0d: stall=%b flush=%b, want 1 1", k, StallFD, FlushM);
      end
      tick();
      #1;
    end
    exp = sbq.size() > 0 ? sbq.pop_front() : 64'hx;
    n_tests++;
    if (k !== exp_lat(b1, 1'b1) || StallFD !== 1'b0 || HiOut !== exp[63:32] || LoOut !== exp[31:0]) begin
      n_fail++;
      $display("FAIL b2b_first: cycles=%0d stall=%b hi=%h lo=%h, want %0d 0 %h %h",
               k, StallFD, HiOut, LoOut, exp_lat(b1, 1'b1), exp[63:32], exp[31:0]);
    end
    sbq.push_back(ref_prod(a2, b2, 1'b0));
    tick();
    StartMultE = 1'b0;
    #1;
    k = 0;
    while (MultBusy === 1'b1 && k < 200) begin
      k++;
      tick();
      #1;
    end
    exp = sbq.size() > 0 ? sbq.pop_front() : 64'hx;
    n_tests++;
    if (k !== exp_lat(b2, 1'b0) || HiOut !== exp[63:32] || LoOut !== exp[31:0]) begin
      n_fail++;
      $display("FAIL b2b_second: cycles=%0d hi=%h lo=%h, want %0d %h %h",
               k, HiOut, LoOut, exp_lat(b2, 1'b0), exp[63:32], exp[31:0]);
    end
    cur_hi = exp[63:32];
    cur_lo = exp[31:0];
    tick();
  endtask

  task automatic test_reset_mid_run();
    StartMultE = 1'b1; MultSignE = 1'b0; SrcAE = 32'hFFFF_FFFF; SrcBE = 32'hFFFF_FFFF; OutSelectE = 2'b00;
    tick();
    StartMultE = 1'b0; OutSelectE = 2'b10;
    repeat (5) tick();
    Rst_n = 1'b0;
    #1;
    n_tests++;
    if (MultBusy !== 1'b0 || StallFD !== 1'b0 || FlushM !== 1'b0 || HiOut !== 0 || LoOut !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b stall=%b flush=%b hi=%h lo=%h, want 0 0 0 0 0",
               MultBusy, StallFD, FlushM, HiOut, LoOut);
    end
    tick();
    Rst_n = 1'b1;
    repeat (N + 4) tick();
    n_tests++;
    if (MultBusy !== 1'b0 || HiOut !== 0 || LoOut !== 0 || HiLoOutE !== 0) begin
      n_fail++;
      $display("FAIL no_late_writeback: busy=%b hi=%h lo=%h hilo=%h, want 0 0 0 0",
               MultBusy, HiOut, LoOut, HiLoOutE);
    end
    cur_hi = '0;
    cur_lo = '0;
    OutSelectE = 2'b00;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_reset_mid_run();
    do_mult(32'd7, 32'd6, 1'b0, 2'b10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
